flag_event_logger: RTL and testbench

FLAG_EVENT_LOGGER -- requirements
Module: flag_event_logger

---
 rtl/flag_event_pkg.sv | 16 +
 rtl/flag_event_fifo.sv | 50 +++++
 rtl/flag_event_logger.sv | 84 ++++++++
 tb/tb_flag_event_logger.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/flag_event_pkg.sv
// Shared defaults, event record layout and FSM encoding for the flag event logger.
package flag_event_pkg;
  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 4;

  // Event record at the default timestamp width; the top re-declares the same layout at its own TS_W.
  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic                val;
  } evt_t;

  typedef enum logic [0:0] {
    ARMED    = 1'b0,
    TRACKING = 1'b1
  } state_e;
endpackage

// File: rtl/flag_event_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is accepted only alongside a pop.
module flag_event_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_push, do_pop;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  // Head is forced to zero when empty so outputs read clean straight out of reset.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q[AW-1:0]] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/flag_event_logger.sv
// Timestamps edges of a monitored flag (plus an initial snapshot when first enabled) into a FIFO.
module flag_event_logger
  import flag_event_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    flag_in,
  input  logic                    clr_ovf,
  input  logic                    evt_ready,
  output logic                    evt_valid,
  output logic [TS_W-1:0]         evt_ts,
  output logic                    evt_val,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);
  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic            val;
  } evt_w_t;

  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
  logic            flag_q, flag_d;
  logic            overflow_q, overflow_d;
  state_e          state_q, state_d;
  logic            log_evt, drop, full, empty;
  evt_w_t          evt_in, evt_head;

  assign evt_in    = '{ts: ts_cnt_q, val: flag_in};
  assign evt_valid = !empty;
  assign evt_ts    = evt_head.ts;
  assign evt_val   = evt_head.val;
  assign overflow  = overflow_q;

  always_comb begin
    ts_cnt_d = ts_cnt_q + TS_W'(1);
    flag_d   = flag_in;
    state_d  = state_q;
    log_evt  = 1'b0;
    case (state_q)
      ARMED: if (en) begin
        log_evt = 1'b1;
        state_d = TRACKING;
      end
      TRACKING: log_evt = en && (flag_in != flag_q);
      default:  state_d = ARMED;
    endcase
    // Full implies non-empty, so a ready consumer always frees a slot this edge.
    drop       = log_evt && full && !evt_ready;
    overflow_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q   <= '0;
      flag_q     <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= ARMED;
    end else begin
      ts_cnt_q   <= ts_cnt_d;
      flag_q     <= flag_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  flag_event_fifo #(
    .W     ($bits(evt_w_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (log_evt),
    .pop   (evt_ready),
    .din   (evt_in),
    .dout  (evt_head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule

// File: tb/tb_flag_event_logger.sv
// Directed bench: default instance for main behaviour, TS_W=4 instance for timestamp wrap.
module tb_flag_event_logger;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, flag_in, clr_ovf, evt_ready;
  logic        evt_valid, evt_val, overflow;
  logic [15:0] evt_ts;
  logic [2:0]  count;

  logic        rst4, en4, flag4, clr4, ready4;
  logic        valid4, val4, ovf4;
  logic [3:0]  ts4o;
  logic [2:0]  count4;

  int checks = 0;
  int failures = 0;
  int ts = 0;
  int ts4 = 0;
  logic [15:0] exp_ts [8];
  logic        exp_v  [8];
  int          order  [4];

  flag_event_logger dut (
    .clk(clk), .rst(rst), .en(en), .flag_in(flag_in), .clr_ovf(clr_ovf),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_ts(evt_ts),
    .evt_val(evt_val), .count(count), .overflow(overflow)
  );

  flag_event_logger #(.TS_W(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .flag_in(flag4), .clr_ovf(clr4),
    .evt_ready(ready4), .evt_valid(valid4), .evt_ts(ts4o),
    .evt_val(val4), .count(count4), .overflow(ovf4)
  );

  task automatic step();
    @(posedge clk);
    #1;
    ts  = (ts + 1) % 65536;
    ts4 = (ts4 + 1) % 16;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1; en = 0; flag_in = 0; clr_ovf = 0; evt_ready = 0;
    rst4 = 1; en4 = 0; flag4 = 0; clr4 = 0; ready4 = 0;
    #2;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ts", 32'(evt_ts), 32'd0);
    chk("rst_val", 32'(evt_val), 32'd0);
    chk("rst4_valid", 32'(valid4), 32'd0);
    step(); step();

    // Initial snapshot on first enabled edge.
    en = 1; flag_in = 0; rst = 0; ts = 0;
    step();
    chk("init_valid", 32'(evt_valid), 32'd1);
    chk("init_ts", 32'(evt_ts), 32'd0);
    chk("init_val", 32'(evt_val), 32'd0);
    chk("init_count", 32'(count), 32'd1);
    evt_ready = 1;
    step();
    chk("init_pop_count", 32'(count), 32'd0);

    // Toggles at ts 10, 20, 30 with a ready consumer.
    while (ts != 10) step();
    flag_in = 1; step();
    chk("t10_ts", 32'(evt_ts), 32'd10);
    chk("t10_val", 32'(evt_val), 32'd1);
    chk("t10_count", 32'(count), 32'd1);
    while (ts != 20) step();
    flag_in = 0; step();
    chk("t20_ts", 32'(evt_ts), 32'd20);
    chk("t20_val", 32'(evt_val), 32'd0);
    while (ts != 30) step();
    flag_in = 1; step();
    chk("t30_ts", 32'(evt_ts), 32'd30);
    chk("t30_val", 32'(evt_val), 32'd1);
    step();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(evt_valid), 32'd0);

    // Six toggles into a stalled FIFO of depth 4.
    evt_ready = 0;
    for (int i = 0; i < 6; i++) begin
      exp_ts[i] = 16'(ts);
      flag_in = ~flag_in;
      exp_v[i] = flag_in;
      step();
      if (i == 3) chk("full_no_ovf", 32'(overflow), 32'd0);
    end
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head_ts", 32'(evt_ts), 32'(exp_ts[0]));
    chk("ovf_head_val", 32'(evt_val), 32'(exp_v[0]));

    // Clear coinciding with another drop keeps overflow set.
    clr_ovf = 1; flag_in = ~flag_in; step();
    clr_ovf = 0;
    chk("clr_drop_ovf", 32'(overflow), 32'd1);
    chk("clr_drop_count", 32'(count), 32'd4);
    clr_ovf = 1; step();
    clr_ovf = 0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("hold_ts", 32'(evt_ts), 32'(exp_ts[0]));

    // Push and pop together while full.
    evt_ready = 1;
    exp_ts[6] = 16'(ts);
    flag_in = ~flag_in;
    exp_v[6] = flag_in;
    step();
    evt_ready = 0;
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'd0);
    order[0] = 1; order[1] = 2; order[2] = 3; order[3] = 6;
    evt_ready = 1;
    for (int j = 0; j < 4; j++) begin
      chk("order_ts", 32'(evt_ts), 32'(exp_ts[order[j]]));
      chk("order_val", 32'(evt_val), 32'(exp_v[order[j]]));
      step();
    end
    chk("order_empty", 32'(count), 32'd0);

    // Reset with three stored events.
    evt_ready = 0;
    for (int k = 0; k < 3; k++) begin
      flag_in = ~flag_in;
      step();
    end
    chk("pre_rst_count", 32'(count), 32'd3);
    #2; rst = 1; #1;
    chk("mid_rst_valid", 32'(evt_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ts", 32'(evt_ts), 32'd0);
    step();
    flag_in = 1; en = 1; rst = 0; ts = 0;
    step();
    chk("rearm_count", 32'(count), 32'd1);
    chk("rearm_ts", 32'(evt_ts), 32'd0);
    chk("rearm_val", 32'(evt_val), 32'd1);

    // Timestamp wrap on the 4-bit instance.
    en4 = 1; flag4 = 0; ready4 = 1; rst4 = 0; ts4 = 0;
    step();
    while (ts4 != 15) step();
    ready4 = 0; flag4 = 1; step();
    flag4 = 0; step();
    chk("wrap_count", 32'(count4), 32'd2);
    chk("wrap_ts15", 32'(ts4o), 32'd15);
    chk("wrap_val15", 32'(val4), 32'd1);
    ready4 = 1; step();
    ready4 = 0;
    chk("wrap_ts0", 32'(ts4o), 32'd0);
    chk("wrap_val0", 32'(val4), 32'd0);
    chk("wrap_count1", 32'(count4), 32'd1);
    chk("wrap_ovf", 32'(ovf4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
